button_debounce_nbit: RTL and testbench

- Parametrised successor to the n-bit button edge monitor.
- Synchronises, debounces and edge-detects WIDTH mechanical push-buttons.
- Emits one-cycle press and release pulses per key, plus a priority-encoded key code for the lock's code-entry FSM.
- Sits between the board KEY pins and the digital-lock controller.

---
 rtl/button_debounce_nbit.sv | 150 +++++++++++++++
 tb/tb_button_debounce_nbit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_nbit.sv
// Synchronise, debounce and edge-detect WIDTH push-buttons; priority-encoded key code.
// Optional auto-repeat of keyEdge while held: define BUTTON_AUTO_REPEAT_EN.
module button_debounce_nbit #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [WIDTH-1:0]                         key,
  output logic [WIDTH-1:0]                         keyState,
  output logic [WIDTH-1:0]                         keyEdge,
  output logic [WIDTH-1:0]                         keyRelease,
  output logic                                     anyPress,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] keyCode
);

  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNTW-1:0]  CNT_MAX = CNTW'(DEBOUNCE_CYCLES);
  localparam logic [WIDTH-1:0] IDLE    = (ACTIVE_LOW != 0) ? '1 : '0;

  if (WIDTH < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_debounce_nbit: all parameters must be >= 1");
  end

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t           st  [WIDTH];
  logic [CNTW-1:0]  cnt [WIDTH];
  logic [WIDTH-1:0] sync1, sync2, raw;
  logic [WIDTH-1:0] press_hit, release_hit, edge_nxt;
  logic [CW-1:0]    code_nxt;
  logic             found;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0]    rcnt [WIDTH];
  logic [WIDTH-1:0] rdone, hold, rpt_hit;
`endif

  always_comb begin
    raw = sync2 ^ IDLE;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      press_hit[i]   = (st[i] == PRESS_WAIT)   &&  raw[i] && (cnt[i] == CNT_MAX);
      release_hit[i] = (st[i] == RELEASE_WAIT) && !raw[i] && (cnt[i] == CNT_MAX);
      keyState[i]    = (st[i] == PRESSED) || (st[i] == RELEASE_WAIT);
    end
`ifdef BUTTON_AUTO_REPEAT_EN
    // The repeat timer only advances on samples that agree with the held level.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      hold[i]    = keyState[i] && raw[i];
      rpt_hit[i] = hold[i] &&
                   ((rcnt[i] + RW'(1)) == (rdone[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
    end
    edge_nxt = press_hit | rpt_hit;
`else
    edge_nxt = press_hit;
`endif
    code_nxt = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (edge_nxt[i] && !found) begin
        code_nxt = CW'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= IDLE;
      sync2      <= IDLE;
      keyEdge    <= '0;
      keyRelease <= '0;
      anyPress   <= 1'b0;
      keyCode    <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        st[i]  <= RELEASED;
        cnt[i] <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rcnt[i] <= '0;
`endif
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      rdone <= '0;
`endif
    end else begin
      sync1      <= key;
      sync2      <= sync1;
      keyEdge    <= edge_nxt;
      keyRelease <= release_hit;
      anyPress   <= |edge_nxt;
      keyCode    <= code_nxt;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case (st[i])
          RELEASED: begin
            if (raw[i]) begin
              st[i]  <= PRESS_WAIT;
              cnt[i] <= CNTW'(1);
            end
          end
          PRESS_WAIT: begin
            if (!raw[i]) begin
              st[i]  <= RELEASED;
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              st[i]  <= PRESSED;
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNTW'(1);
            end
          end
          PRESSED: begin
            if (!raw[i]) begin
              st[i]  <= RELEASE_WAIT;
              cnt[i] <= CNTW'(1);
            end
          end
          RELEASE_WAIT: begin
            if (raw[i]) begin
              st[i]  <= PRESSED;
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
              st[i]  <= RELEASED;
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNTW'(1);
            end
          end
        endcase
`ifdef BUTTON_AUTO_REPEAT_EN
        if (press_hit[i] || st[i] == RELEASED) begin
          rcnt[i]  <= '0;
          rdone[i] <= 1'b0;
        end else if (rpt_hit[i]) begin
          rcnt[i]  <= '0;
          rdone[i] <= 1'b1;
        end else if (hold[i]) begin
          rcnt[i] <= rcnt[i] + RW'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_button_debounce_nbit.sv
// Self-checking bench for button_debounce_nbit: directed table, corner sequences and
// randomized bouncing keys against a run-length reference model.
module tb_button_debounce_nbit;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] key, keyState, keyEdge, keyRelease;
  logic         anyPress;
  logic [1:0]   keyCode;

  always #5 clock = ~clock;

  button_debounce_nbit #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .key(key), .keyState(keyState),
    .keyEdge(keyEdge), .keyRelease(keyRelease), .anyPress(anyPress), .keyCode(keyCode)
  );

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: 2-sample delay line, then a key flips its accepted level once
  // D+1 consecutive samples disagree with it.
  logic [W-1:0] s1, s2, acc, m_st, m_edge, m_rel;
  logic         m_any;
  logic [1:0]   m_code;
  int           run  [W];
  int           held [W];

  task automatic model_edge(input logic [W-1:0] k, input logic r);
    logic raw;
    m_edge = '0;
    m_rel  = '0;
    if (r) begin
      s1 = '0; s2 = '0; acc = '0;
      for (int i = 0; i < W; i++) begin run[i] = 0; held[i] = 0; end
    end else begin
      for (int i = 0; i < W; i++) begin
        raw   = s2[i];
        s2[i] = s1[i];
        s1[i] = ~k[i];
        if (raw != acc[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            acc[i]  = raw;
            run[i]  = 0;
            held[i] = 0;
            if (raw) m_edge[i] = 1'b1;
            else     m_rel[i]  = 1'b1;
          end
        end else begin
          run[i] = 0;
`ifdef BUTTON_AUTO_REPEAT_EN
          if (acc[i]) begin
            held[i]++;
            if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)) m_edge[i] = 1'b1;
          end
`endif
        end
      end
    end
    m_st   = acc;
    m_any  = |m_edge;
    m_code = '0;
    for (int i = W - 1; i >= 0; i--) if (m_edge[i]) m_code = 2'(i);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick(input logic [W-1:0] k, input logic r);
    key   = k;
    reset = r;
    @(posedge clock);
    model_edge(k, r);
    @(negedge clock);
    ncmp++;
    if ({keyState, keyEdge, keyRelease, anyPress, keyCode} !== {m_st, m_edge, m_rel, m_any, m_code}) begin
      nfail++;
      $display("FAIL model @%0t: got st=%b edge=%b rel=%b any=%b code=%0d, expected st=%b edge=%b rel=%b any=%b code=%0d",
               $time, keyState, keyEdge, keyRelease, anyPress, keyCode, m_st, m_edge, m_rel, m_any, m_code);
    end
  endtask

  typedef struct {
    logic [W-1:0] key;
    logic [W-1:0] st, edg, rel;
    logic         any;
    logic [1:0]   code;
  } vec_t;
  vec_t vt [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cnt_e, cnt_r, j0;
    logic         saw;
    logic [W-1:0] kv;
    int           rem [W];
    int           bounce [9];

    // key[2] pressed at row 0, released at row 10: pulses D+2 rows after each change
    for (int i = 0; i < 18; i++) begin
      vt[i].key  = (i < 10) ? 4'b1011 : 4'b1111;
      vt[i].st   = (i >= 6 && i < 16) ? 4'b0100 : 4'b0000;
      vt[i].edg  = (i == 6)  ? 4'b0100 : 4'b0000;
      vt[i].rel  = (i == 16) ? 4'b0100 : 4'b0000;
      vt[i].any  = (i == 6);
      vt[i].code = (i == 6)  ? 2'd2 : 2'd0;
    end

    key = '1; reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111, 1'b1);
      chk("reset_hold", {keyState, keyEdge, keyRelease, anyPress, keyCode}, 0);
    end
    for (int i = 0; i < 50; i++) begin
      tick(4'b1111, 1'b0);
      chk("post_reset", {keyState, keyEdge, keyRelease, anyPress, keyCode}, 0);
    end

    for (int i = 0; i < 18; i++) begin
      tick(vt[i].key, 1'b0);
      chk("tbl_state",   keyState,   vt[i].st);
      chk("tbl_edge",    keyEdge,    vt[i].edg);
      chk("tbl_release", keyRelease, vt[i].rel);
      chk("tbl_any_code", {anyPress, keyCode}, {vt[i].any, vt[i].code});
    end

    // Bounce on key[0]: low 3, high 2, low 3, then high
    bounce = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
    saw = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick({3'b111, 1'(bounce[i])}, 1'b0);
      if (keyEdge[0] || keyState[0]) saw = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      tick(4'b1111, 1'b0);
      if (keyEdge[0] || keyState[0]) saw = 1'b1;
    end
    chk("bounce_rejected", saw, 0);

    // key[1] and key[3] pressed together
    cnt_e = 0;
    for (int j = 0; j < 10; j++) begin
      tick(4'b0101, 1'b0);
      if (keyEdge != 0) cnt_e++;
      if (j == 6) begin
        chk("simul_edge", keyEdge, 4'b1010);
        chk("simul_code", keyCode, 1);
        chk("simul_any",  anyPress, 1);
      end
    end
    chk("simul_edge_once", cnt_e, 1);
    cnt_r = 0;
    for (int j = 0; j < 10; j++) begin
      tick(4'b1101, 1'b0);
      if (keyRelease != 0) cnt_r++;
      if (j == 6) chk("release_k3", keyRelease, 4'b1000);
    end
    chk("release_k3_once", cnt_r, 1);
    for (int j = 0; j < 10; j++) tick(4'b1111, 1'b0);

    // key[0] held through a one-cycle reset
    for (int j = 0; j < 10; j++) tick(4'b1110, 1'b0);
    chk("hold_before_reset", keyState, 4'b0001);
    tick(4'b1110, 1'b1);
    chk("reset_mid_clears", {keyState, keyRelease, keyEdge}, 0);
    cnt_r = 0; cnt_e = 0; j0 = -1;
    for (int j = 0; j < 10; j++) begin
      tick(4'b1110, 1'b0);
      if (keyRelease != 0) cnt_r++;
      if (keyEdge[0]) begin cnt_e++; if (j0 < 0) j0 = j; end
    end
    chk("reset_no_release", cnt_r, 0);
    chk("reset_new_press_at", j0, D + 2);
    chk("reset_new_press_once", cnt_e, 1);
    for (int j = 0; j < 10; j++) tick(4'b1111, 1'b0);

`ifdef BUTTON_AUTO_REPEAT_EN
    j0 = -1;
    for (int j = 0; j < 20 && j0 < 0; j++) begin
      tick(4'b1101, 1'b0);
      if (keyEdge[1]) j0 = j;
    end
    chk("repeat_first_press", j0, D + 2);
    for (int off = 1; off <= 56; off++) begin
      tick(4'b1101, 1'b0);
      chk("repeat_edge", keyEdge[1],
          (off == 20 || off == 28 || off == 36 || off == 44 || off == 52) ? 1 : 0);
    end
    cnt_e = 0;
    for (int j = 0; j < 20; j++) begin
      tick(4'b1111, 1'b0);
      if (keyEdge[1]) cnt_e++;
    end
    chk("repeat_none_after_release", cnt_e, 0);
`endif

    // Randomized bouncing keys with occasional resets
    kv = 4'b1111;
    for (int i = 0; i < W; i++) rem[i] = $urandom_range(1, 2 * D + 4);
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < W; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          kv[i]  = ~kv[i];
          rem[i] = $urandom_range(1, 2 * D + 4);
        end
      end
      tick(kv, ($urandom_range(0, 399) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
